// File: rtl/proc_pkg.sv
// Shared processor definitions: word layout, opcode constants and the
// instruction feeder state encoding.
package proc_pkg;

    localparam int DATA_W  = 16;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

    localparam logic [3:0] OP_MV  = 4'b0000;
    localparam logic [3:0] OP_MVI = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        IMM   = 3'd2,
        WAIT  = 3'd3,
        NEXT  = 3'd4,
        HALT  = 3'd5,
        ERROR = 3'd6
    } feeder_state_e;

    function automatic logic op_matches(input logic [3:0] op, input logic [3:0] ref_op);
        return (op == ref_op);
    endfunction

endpackage

// File: rtl/feeder_prog_mem.sv
// Program store for the instruction feeder: register array with
// synchronous write and combinational read; contents survive reset.
module feeder_prog_mem #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write port; no reset so a loaded program can be re-run after reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_feeder.sv
// Instruction-issuing master: steps through the program store, pulses run
// with each word on Din and waits for done, handling two-word MVI.
module instr_feeder
    import proc_pkg::*;
#(
    parameter int         DATA_W  = proc_pkg::DATA_W,
    parameter int         ADDR_W  = 4,
    parameter logic [3:0] MVI_OP  = OP_MVI,
    parameter int         TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic              done,
    output logic [DATA_W-1:0] Din,
    output logic              run,
    output logic              busy,
    output logic              finished,
    output logic              error,
    output logic [ADDR_W:0]   pc
);

    localparam int PW    = ADDR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT) + 1;

    feeder_state_e     state_q, state_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              run_q, run_d;
    logic              busy_q, busy_d;
    logic              finished_q, finished_d;
    logic              error_q, error_d;
    logic [PW-1:0]     pc_q, pc_d;
    logic [PW-1:0]     len_q, len_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              is_mvi_q, is_mvi_d;

    logic              idle_like_s;
    logic [PW-1:0]     pc_step_s;
    logic [PW-1:0]     rd_ptr_s;
    logic [PW-1:0]     launch_len_s;
    logic [DATA_W-1:0] rd_word_s;
    logic              word_is_mvi_s;
    logic              trunc_s;

    feeder_prog_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i   (clock),
        .we_i    (prog_we && !busy_q),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .raddr_i (rd_ptr_s[ADDR_W-1:0]),
        .rdata_o (rd_word_s)
    );

    assign idle_like_s   = (state_q == IDLE) || (state_q == HALT) || (state_q == ERROR);
    assign pc_step_s     = pc_q + (is_mvi_q ? PW'(2) : PW'(1));
    assign launch_len_s  = idle_like_s ? prog_len : len_q;
    assign word_is_mvi_s = op_matches(rd_word_s[OPC_MSB:OPC_LSB], MVI_OP);
    // An MVI in the last slot has no immediate word; its run is withheld.
    assign trunc_s       = word_is_mvi_s && ((rd_ptr_s + PW'(1)) == launch_len_s);

    // Read pointer: word about to be issued, or the immediate after an MVI.
    always_comb begin
        rd_ptr_s = pc_step_s;
        if (idle_like_s) begin
            rd_ptr_s = '0;
        end else if (state_q == ISSUE) begin
            rd_ptr_s = pc_q + PW'(1);
        end else begin
            rd_ptr_s = pc_step_s;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        din_d    = din_q;
        run_d    = 1'b0;
        pc_d     = pc_q;
        len_d    = len_q;
        timer_d  = timer_q;
        is_mvi_d = is_mvi_q;
        case (state_q)
            IDLE, HALT, ERROR: begin
                if (start) begin
                    len_d   = prog_len;
                    pc_d    = '0;
                    timer_d = '0;
                    if (prog_len == '0) begin
                        state_d = HALT;
                    end else begin
                        state_d  = ISSUE;
                        din_d    = rd_word_s;
                        is_mvi_d = word_is_mvi_s;
                        run_d    = !trunc_s;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ISSUE: begin
                timer_d = timer_q + TMR_W'(1);
                if (is_mvi_q && ((pc_q + PW'(1)) == len_q)) begin
                    state_d = ERROR;
                end else if (is_mvi_q) begin
                    state_d = IMM;
                    din_d   = rd_word_s;
                end else begin
                    state_d = WAIT;
                end
            end
            IMM, WAIT: begin
                if (done) begin
                    state_d = NEXT;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    state_d = ERROR;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            NEXT: begin
                timer_d = '0;
                pc_d    = pc_step_s;
                if (pc_step_s >= len_q) begin
                    state_d = HALT;
                end else begin
                    state_d  = ISSUE;
                    din_d    = rd_word_s;
                    is_mvi_d = word_is_mvi_s;
                    run_d    = !trunc_s;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d     = (state_d == ISSUE) || (state_d == IMM) ||
                     (state_d == WAIT)  || (state_d == NEXT);
        finished_d = (state_d == HALT);
        error_d    = (state_d == ERROR);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            din_q      <= '0;
            run_q      <= 1'b0;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
            error_q    <= 1'b0;
            pc_q       <= '0;
            len_q      <= '0;
            timer_q    <= '0;
            is_mvi_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            din_q      <= din_d;
            run_q      <= run_d;
            busy_q     <= busy_d;
            finished_q <= finished_d;
            error_q    <= error_d;
            pc_q       <= pc_d;
            len_q      <= len_d;
            timer_q    <= timer_d;
            is_mvi_q   <= is_mvi_d;
        end
    end

    assign Din      = din_q;
    assign run      = run_q;
    assign busy     = busy_q;
    assign finished = finished_q;
    assign error    = error_q;
    assign pc       = pc_q;

endmodule

// File: tb/tb_instr_feeder.sv
// Randomized bench for instr_feeder: a program-level model predicts every
// issued word, its pc and the cycle it must appear on, for random done delays.
module tb_instr_feeder;

    localparam int TIMEOUT = 64;

    logic        clock;
    logic        reset;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [15:0] prog_data;
    logic [4:0]  prog_len;
    logic        start;
    logic        done;
    logic [15:0] Din;
    logic        run;
    logic        busy;
    logic        finished;
    logic        error;
    logic [4:0]  pc;

    logic [15:0] model_mem [16];
    int          n_cmp;
    int          n_mis;

    instr_feeder dut (
        .clock     (clock),
        .reset     (reset),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_len  (prog_len),
        .start     (start),
        .done      (done),
        .Din       (Din),
        .run       (run),
        .busy      (busy),
        .finished  (finished),
        .error     (error),
        .pc        (pc)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    function automatic logic [15:0] mem_at(input int a);
        return model_mem[a[3:0]];
    endfunction

    function automatic logic [15:0] rand_word(input bit want_mvi);
        logic [15:0] w;
        w = 16'($urandom);
        if (want_mvi) w[15:12] = 4'h1;
        else if (w[15:12] == 4'h1) w[15:12] = 4'h2;
        return w;
    endfunction

    task automatic load_word(input int a, input logic [15:0] w);
        prog_we   = 1'b1;
        prog_addr = a[3:0];
        prog_data = w;
        step();
        prog_we = 1'b0;
        model_mem[a[3:0]] = w;
    endtask

    // Start a program of len words and follow it word by word.
    task automatic exec_prog(input int len, input int kmin, input int kmax, input bit disturb);
        int          p;
        int          k;
        bit          fin;
        bit          mvi;
        logic [15:0] op;
        logic [15:0] held;
        prog_len = 5'(len);
        start    = 1'b1;
        step();
        start    = 1'b0;
        if (len == 0) begin
            check_eq("len0_fin", finished, 1);
            check_eq("len0_run", run, 0);
            check_eq("len0_busy", busy, 0);
            check_eq("len0_pc", pc, 0);
            return;
        end
        p   = 0;
        fin = 1'b0;
        while (!fin) begin
            op  = mem_at(p);
            mvi = (op[15:12] == 4'h1);
            if (mvi && (p + 1 == len)) begin
                check_eq("trunc_run", run, 0);
                check_eq("trunc_busy", busy, 1);
                step();
                check_eq("trunc_err", error, 1);
                check_eq("trunc_pc", pc, p);
                check_eq("trunc_run2", run, 0);
                fin = 1'b1;
            end else begin
                check_eq("run", run, 1);
                check_eq("din_op", Din, op);
                check_eq("pc", pc, p);
                held = mvi ? mem_at(p + 1) : op;
                k    = $urandom_range(kmin, kmax);
                done = 1'($urandom_range(0, 1));
                for (int j = 1; j <= k; j++) begin
                    step();
                    done    = 1'b0;
                    start   = 1'b0;
                    prog_we = 1'b0;
                    check_eq("wait_run", run, 0);
                    if (j == 1) begin
                        check_eq("din_hold", Din, held);
                        if (disturb) begin
                            start     = 1'b1;
                            prog_len  = 5'd1;
                            prog_we   = 1'b1;
                            prog_addr = 4'd0;
                            prog_data = ~model_mem[0];
                        end
                    end
                    if (j == k) done = 1'b1;
                end
                step();
                done    = 1'b0;
                start   = 1'b0;
                prog_we = 1'b0;
                check_eq("next_busy", busy, 1);
                check_eq("next_run", run, 0);
                check_eq("next_din", Din, held);
                step();
                p = p + (mvi ? 2 : 1);
                if (p >= len) begin
                    check_eq("halt_fin", finished, 1);
                    check_eq("halt_pc", pc, len);
                    check_eq("halt_err", error, 0);
                    check_eq("halt_run", run, 0);
                    fin = 1'b1;
                end
            end
        end
    endtask

    initial begin
        int len;
        n_cmp     = 0;
        n_mis     = 0;
        reset     = 1'b1;
        prog_we   = 1'b0;
        prog_addr = 4'd0;
        prog_data = 16'h0000;
        prog_len  = 5'd0;
        start     = 1'b0;
        done      = 1'b0;
        step();
        step();
        reset = 1'b0;
        check_eq("rst_din", Din, 0);
        check_eq("rst_run", run, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_fin", finished, 0);
        check_eq("rst_err", error, 0);
        check_eq("rst_pc", pc, 0);

        // Two plain words, done two cycles after each run.
        load_word(0, 16'h2000);
        load_word(1, 16'h3000);
        exec_prog(2, 2, 2, 1'b0);

        // MVI with its immediate.
        load_word(0, 16'h1000);
        load_word(1, 16'h0002);
        exec_prog(2, 1, 3, 1'b0);

        // Truncated MVI.
        exec_prog(1, 1, 3, 1'b0);

        // Timeout: done never arrives.
        load_word(0, 16'h2000);
        prog_len = 5'd1;
        start    = 1'b1;
        step();
        start = 1'b0;
        check_eq("to_run", run, 1);
        for (int j = 1; j < TIMEOUT; j++) step();
        check_eq("to_err_early", error, 0);
        check_eq("to_busy_early", busy, 1);
        step();
        check_eq("to_err", error, 1);
        check_eq("to_busy", busy, 0);
        check_eq("to_run2", run, 0);

        // Reset while waiting, then done in IDLE, then re-run from the kept store.
        load_word(1, 16'h3000);
        prog_len = 5'd2;
        start    = 1'b1;
        step();
        start = 1'b0;
        check_eq("rw_run", run, 1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("rw_run0", run, 0);
        check_eq("rw_din", Din, 0);
        check_eq("rw_pc", pc, 0);
        check_eq("rw_busy", busy, 0);
        check_eq("rw_err", error, 0);
        done = 1'b1;
        step();
        done = 1'b0;
        check_eq("idle_done_busy", busy, 0);
        check_eq("idle_done_run", run, 0);
        check_eq("idle_done_fin", finished, 0);
        exec_prog(2, 1, 3, 1'b0);

        // Empty program, then done while halted.
        exec_prog(0, 1, 1, 1'b0);
        done = 1'b1;
        step();
        done = 1'b0;
        check_eq("halt_done_fin", finished, 1);
        check_eq("halt_done_busy", busy, 0);

        // Start and writes while busy are ignored; the second run proves the store.
        for (int a = 0; a < 16; a++) load_word(a, rand_word(1'b0));
        exec_prog(6, 1, 3, 1'b1);
        exec_prog(6, 1, 2, 1'b0);

        for (int it = 0; it < 25; it++) begin
            for (int a = 0; a < 16; a++) load_word(a, rand_word($urandom_range(0, 2) == 0));
            len = $urandom_range(0, 16);
            exec_prog(len, 1, 4, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
